// File: rtl/phy_mgmt_arb.sv
// phy_mgmt_arb: round-robin arbiter sharing one PHY management engine between two
// requesters, with per-transaction timeout supervision and per-port completion.
module phy_mgmt_arb #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 13
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req0_request,
  input  logic [4:0]  i_req0_addr,
  input  logic        i_req0_rdwn,
  input  logic [31:0] i_req0_wr_data,
  output logic        o_req0_done,
  output logic [31:0] o_req0_rd_data,
  output logic        o_req0_err,
  output logic        o_req0_busy,
  input  logic        i_req1_request,
  input  logic [4:0]  i_req1_addr,
  input  logic        i_req1_rdwn,
  input  logic [31:0] i_req1_wr_data,
  output logic        o_req1_done,
  output logic [31:0] o_req1_rd_data,
  output logic        o_req1_err,
  output logic        o_req1_busy,
  output logic        o_phy_request,
  output logic [4:0]  o_phy_addr,
  output logic        o_phy_rdwn,
  output logic [31:0] o_phy_wr_data,
  input  logic        i_phy_done,
  input  logic [31:0] i_phy_rd_data,
  output logic [1:0]  o_grant
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);

  logic [1:0]       state_q, state_d, pend_q, pend_d, grant_q, grant_d, acc, req_in, rdwn_in, rdwn_q;
  logic             last_q, last_d, win, done_ev, tmo_ev;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       addr_in [2];
  logic [4:0]       addr_q [2];
  logic [31:0]      wdata_in [2];
  logic [31:0]      wdata_q [2];
  logic             phy_req_q, phy_req_d, phy_rdwn_q, phy_rdwn_d, rsp_err_q, rsp_err_d;
  logic [4:0]       phy_addr_q, phy_addr_d;
  logic [31:0]      phy_wdata_q, phy_wdata_d, rsp_rd_q, rsp_rd_d;

  assign req_in      = {i_req1_request, i_req0_request};
  assign rdwn_in     = {i_req1_rdwn, i_req0_rdwn};
  assign addr_in[0]  = i_req0_addr;
  assign addr_in[1]  = i_req1_addr;
  assign wdata_in[0] = i_req0_wr_data;
  assign wdata_in[1] = i_req1_wr_data;

  always_comb begin
    // the owner may re-arm during its own RESP cycle; the set below overrides the clear
    acc         = req_in & (~pend_q | ((state_q == RESP) ? grant_q : 2'b00));
    win         = pend_q[1] & (~pend_q[0] | ~last_q);
    done_ev     = ((state_q == ISSUE) || (state_q == WAIT)) && i_phy_done;
    tmo_ev      = (state_q == WAIT) && !i_phy_done && (cnt_q == TMO);
    state_d     = state_q;
    pend_d      = pend_q;
    last_d      = last_q;
    grant_d     = grant_q;
    cnt_d       = cnt_q;
    phy_req_d   = 1'b0;
    phy_addr_d  = phy_addr_q;
    phy_rdwn_d  = phy_rdwn_q;
    phy_wdata_d = phy_wdata_q;
    rsp_rd_d    = '0;
    rsp_err_d   = 1'b0;
    case (state_q)
      IDLE: if (|pend_q) begin
        state_d     = ISSUE;
        phy_req_d   = 1'b1;
        grant_d     = win ? 2'b10 : 2'b01;
        phy_addr_d  = addr_q[win];
        phy_rdwn_d  = rdwn_q[win];
        phy_wdata_d = wdata_q[win];
        cnt_d       = '0;
      end
      ISSUE, WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (done_ev) begin
          state_d  = RESP;
          rsp_rd_d = i_phy_rd_data;
        end else if (tmo_ev) begin
          state_d   = RESP;
          rsp_rd_d  = '1;
          rsp_err_d = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      default: begin
        state_d     = IDLE;
        pend_d      = pend_q & ~grant_q;
        last_d      = grant_q[1];
        grant_d     = 2'b00;
        phy_addr_d  = '0;
        phy_rdwn_d  = 1'b0;
        phy_wdata_d = '0;
      end
    endcase
    pend_d = pend_d | acc;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      pend_q      <= '0;
      last_q      <= 1'b1;
      grant_q     <= '0;
      cnt_q       <= '0;
      phy_req_q   <= 1'b0;
      phy_addr_q  <= '0;
      phy_rdwn_q  <= 1'b0;
      phy_wdata_q <= '0;
      rsp_rd_q    <= '0;
      rsp_err_q   <= 1'b0;
      rdwn_q      <= '0;
      addr_q[0]   <= '0;
      addr_q[1]   <= '0;
      wdata_q[0]  <= '0;
      wdata_q[1]  <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      last_q      <= last_d;
      grant_q     <= grant_d;
      cnt_q       <= cnt_d;
      phy_req_q   <= phy_req_d;
      phy_addr_q  <= phy_addr_d;
      phy_rdwn_q  <= phy_rdwn_d;
      phy_wdata_q <= phy_wdata_d;
      rsp_rd_q    <= rsp_rd_d;
      rsp_err_q   <= rsp_err_d;
      for (int k = 0; k < 2; k++) begin
        if (acc[k]) begin
          addr_q[k]  <= addr_in[k];
          rdwn_q[k]  <= rdwn_in[k];
          wdata_q[k] <= wdata_in[k];
        end
      end
    end
  end

  assign o_phy_request  = phy_req_q;
  assign o_phy_addr     = phy_addr_q;
  assign o_phy_rdwn     = phy_rdwn_q;
  assign o_phy_wr_data  = phy_wdata_q;
  assign o_grant        = grant_q;
  assign o_req0_busy    = pend_q[0];
  assign o_req1_busy    = pend_q[1];
  assign o_req0_done    = (state_q == RESP) & grant_q[0];
  assign o_req1_done    = (state_q == RESP) & grant_q[1];
  assign o_req0_rd_data = grant_q[0] ? rsp_rd_q : '0;
  assign o_req1_rd_data = grant_q[1] ? rsp_rd_q : '0;
  assign o_req0_err     = rsp_err_q & grant_q[0];
  assign o_req1_err     = rsp_err_q & grant_q[1];
endmodule

// File: tb/tb_phy_mgmt_arb.sv
// tb_phy_mgmt_arb: vector table for arbitration and handshakes, directed sequences
// for timeout, dropped pulses, back-to-back re-arm and mid-transaction reset.
module tb_phy_mgmt_arb;
  localparam int T = 40;

  logic        i_clk = 1'b0, i_rst_n = 1'b0;
  logic        i_req0_request = 0, i_req0_rdwn = 0, i_req1_request = 0, i_req1_rdwn = 0;
  logic [4:0]  i_req0_addr = 0, i_req1_addr = 0;
  logic [31:0] i_req0_wr_data = 0, i_req1_wr_data = 0, i_phy_rd_data = 0;
  logic        i_phy_done = 0;
  logic        o_req0_done, o_req0_err, o_req0_busy, o_req1_done, o_req1_err, o_req1_busy;
  logic [31:0] o_req0_rd_data, o_req1_rd_data, o_phy_wr_data;
  logic        o_phy_request, o_phy_rdwn;
  logic [4:0]  o_phy_addr;
  logic [1:0]  o_grant;

  phy_mgmt_arb #(.TIMEOUT_CYCLES(T), .CNT_W(6)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req0_request(i_req0_request), .i_req0_addr(i_req0_addr), .i_req0_rdwn(i_req0_rdwn),
    .i_req0_wr_data(i_req0_wr_data), .o_req0_done(o_req0_done), .o_req0_rd_data(o_req0_rd_data),
    .o_req0_err(o_req0_err), .o_req0_busy(o_req0_busy),
    .i_req1_request(i_req1_request), .i_req1_addr(i_req1_addr), .i_req1_rdwn(i_req1_rdwn),
    .i_req1_wr_data(i_req1_wr_data), .o_req1_done(o_req1_done), .o_req1_rd_data(o_req1_rd_data),
    .o_req1_err(o_req1_err), .o_req1_busy(o_req1_busy),
    .o_phy_request(o_phy_request), .o_phy_addr(o_phy_addr), .o_phy_rdwn(o_phy_rdwn),
    .o_phy_wr_data(o_phy_wr_data), .i_phy_done(i_phy_done), .i_phy_rd_data(i_phy_rd_data),
    .o_grant(o_grant)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic rst, q0, w0, q1, w1, pd, pr, prw;
    logic [4:0] a0, a1, pa;
    logic [31:0] prd, rd;
    logic [1:0] gr, dn, er, bz;
  } vec_t;

  vec_t tv[$];
  int total = 0, bad = 0;
  int n_pr = 0, n_d0 = 0, n_d1 = 0;
  int b_pr, b_d0, b_d1;
  logic early;

  always @(negedge i_clk) begin
    if (o_phy_request) n_pr++;
    if (o_req0_done) n_d0++;
    if (o_req1_done) n_d1++;
  end

  task automatic add(input logic rst, q0, input logic [4:0] a0, input logic w0,
                     input logic q1, input logic [4:0] a1, input logic w1,
                     input logic pd, input logic [31:0] prd,
                     input logic pr, input logic [4:0] pa, input logic prw,
                     input logic [1:0] gr, dn, input logic [31:0] rd, input logic [1:0] er, bz);
    vec_t v;
    v.rst = rst; v.q0 = q0; v.a0 = a0; v.w0 = w0; v.q1 = q1; v.a1 = a1; v.w1 = w1;
    v.pd = pd; v.prd = prd; v.pr = pr; v.pa = pa; v.prw = prw;
    v.gr = gr; v.dn = dn; v.rd = rd; v.er = er; v.bz = bz;
    tv.push_back(v);
  endtask

  task automatic step;
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, a, e);
    end
  endtask

  task automatic go(input int p, input logic [4:0] a, input logic w, input logic [31:0] d);
    if (p == 0) begin
      i_req0_request = 1; i_req0_addr = a; i_req0_rdwn = w; i_req0_wr_data = d;
    end else begin
      i_req1_request = 1; i_req1_addr = a; i_req1_rdwn = w; i_req1_wr_data = d;
    end
    step;
    i_req0_request = 0;
    i_req1_request = 0;
  endtask

  initial begin
    logic [78:0] act, exp;
    add(1, 0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,0,0,0);
    // single read, engine answers in WAIT
    add(0, 1,5'h11,1, 0,0,0, 0,0, 0,0,0, 0,0,0,0,0);
    add(0, 0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,0,0,1);
    add(0, 0,0,0, 0,0,0, 0,0, 1,5'h11,1, 1,0,0,0,1);
    add(0, 0,0,0, 0,0,0, 0,0, 0,0,0, 1,0,0,0,1);
    add(0, 0,0,0, 0,0,0, 0,0, 0,0,0, 1,0,0,0,1);
    add(0, 0,0,0, 0,0,0, 0,0, 0,0,0, 1,0,0,0,1);
    add(0, 0,0,0, 0,0,0, 1,32'h0000_8000, 0,0,0, 1,0,0,0,1);
    add(0, 0,0,0, 0,0,0, 0,0, 0,0,0, 1,1,32'h0000_8000,0,1);
    add(0, 0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,0,0,0);
    add(1, 0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,0,0,0);
    // contention after reset: port 0 then port 1 (done arrives in ISSUE for port 1)
    add(0, 1,5'h02,1, 1,5'h03,0, 0,0, 0,0,0, 0,0,0,0,0);
    add(0, 0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,0,0,3);
    add(0, 0,0,0, 0,0,0, 0,0, 1,5'h02,1, 1,0,0,0,3);
    add(0, 0,0,0, 0,0,0, 1,32'h1234_5678, 0,0,0, 1,0,0,0,3);
    add(0, 0,0,0, 0,0,0, 0,0, 0,0,0, 1,1,32'h1234_5678,0,3);
    add(0, 0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,0,0,2);
    add(0, 0,0,0, 0,0,0, 1,32'h0000_BEEF, 1,5'h03,0, 2,0,0,0,2);
    add(0, 0,0,0, 0,0,0, 0,0, 0,0,0, 2,2,32'h0000_BEEF,0,2);
    add(0, 0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,0,0,0);
    // port 0 alone, so port 0 becomes last served
    add(0, 1,5'h04,1, 0,0,0, 0,0, 0,0,0, 0,0,0,0,0);
    add(0, 0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,0,0,1);
    add(0, 0,0,0, 0,0,0, 1,32'h1, 1,5'h04,1, 1,0,0,0,1);
    add(0, 0,0,0, 0,0,0, 0,0, 0,0,0, 1,1,32'h1,0,1);
    add(0, 0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,0,0,0);
    // simultaneous pulses again: port 1 first now
    add(0, 1,5'h06,1, 1,5'h07,0, 0,0, 0,0,0, 0,0,0,0,0);
    add(0, 0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,0,0,3);
    add(0, 0,0,0, 0,0,0, 0,0, 1,5'h07,0, 2,0,0,0,3);
    add(0, 0,0,0, 0,0,0, 1,32'h2, 0,0,0, 2,0,0,0,3);
    add(0, 0,0,0, 0,0,0, 0,0, 0,0,0, 2,2,32'h2,0,3);
    add(0, 0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,0,0,1);
    add(0, 0,0,0, 0,0,0, 1,32'h3, 1,5'h06,1, 1,0,0,0,1);
    add(0, 0,0,0, 0,0,0, 0,0, 0,0,0, 1,1,32'h3,0,1);
    add(0, 0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,0,0,0);

    repeat (2) @(posedge i_clk);
    #1;
    foreach (tv[i]) begin
      i_rst_n = !tv[i].rst;
      i_req0_request = tv[i].q0; i_req0_addr = tv[i].a0; i_req0_rdwn = tv[i].w0;
      i_req1_request = tv[i].q1; i_req1_addr = tv[i].a1; i_req1_rdwn = tv[i].w1;
      i_phy_done = tv[i].pd; i_phy_rd_data = tv[i].prd;
      #1;
      act = {o_phy_request, tv[i].pr ? o_phy_addr : 5'd0, tv[i].pr ? o_phy_rdwn : 1'b0, o_grant,
             o_req1_done, o_req0_done, o_req1_err, o_req0_err, o_req1_busy, o_req0_busy,
             o_req0_rd_data, o_req1_rd_data};
      exp = {tv[i].pr, tv[i].pr ? tv[i].pa : 5'd0, tv[i].pr ? tv[i].prw : 1'b0, tv[i].gr,
             tv[i].dn, tv[i].er, tv[i].bz,
             tv[i].dn[0] ? tv[i].rd : 32'd0, tv[i].dn[1] ? tv[i].rd : 32'd0};
      total++;
      if (act !== exp) begin
        bad++;
        $display("FAIL row%0d got=%h want=%h", i, act, exp);
      end
      i_rst_n = 1;
      step;
    end
    i_req0_request = 0; i_req1_request = 0; i_phy_done = 0; i_phy_rd_data = 0;

    // timeout on a port 1 write, then a late done that must be ignored
    go(1, 5'h09, 0, 32'h5A5A_0001);
    step;
    chk("to_issue", {o_phy_request, o_phy_addr, o_phy_rdwn, o_grant}, {1'b1, 5'h09, 1'b0, 2'b10});
    chk("to_wdata", o_phy_wr_data, 32'h5A5A_0001);
    early = 0;
    for (int k = 1; k <= T; k++) begin
      step;
      early |= o_req0_done | o_req1_done;
    end
    chk("to_early", early, 0);
    step;
    chk("to_done", {o_req0_done, o_req1_done, o_req1_err, o_req1_rd_data}, {1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF});
    step;
    b_d0 = n_d0; b_d1 = n_d1;
    i_phy_done = 1; i_phy_rd_data = 32'h1234;
    step;
    i_phy_done = 0;
    repeat (3) step;
    chk("late_done", n_d0 + n_d1 - b_d0 - b_d1, 0);
    chk("late_busy", {o_req1_busy, o_req0_busy}, 0);

    // done and timeout in the same cycle: done wins
    go(0, 5'h0C, 1, 0);
    step;
    repeat (T) step;
    i_phy_done = 1; i_phy_rd_data = 32'h4242;
    step;
    i_phy_done = 0;
    chk("tie_done", {o_req0_done, o_req0_err, o_req0_rd_data}, {1'b1, 1'b0, 32'h4242});
    step;

    // second pulse from port 0 while its first request is in WAIT is dropped
    b_pr = n_pr; b_d0 = n_d0;
    go(0, 5'h11, 1, 0);
    step;
    chk("drop_issue", {o_phy_request, o_phy_addr}, {1'b1, 5'h11});
    step;
    i_req0_request = 1; i_req0_addr = 5'h01;
    step;
    i_req0_request = 0;
    step;
    step;
    i_phy_done = 1; i_phy_rd_data = 32'hCAFE;
    step;
    i_phy_done = 0;
    chk("drop_done", {o_req0_done, o_req0_rd_data}, {1'b1, 32'hCAFE});
    repeat (8) step;
    chk("drop_nreq", n_pr - b_pr, 1);
    chk("drop_ndone", n_d0 - b_d0, 1);
    chk("drop_busy", o_req0_busy, 0);

    // port 1 re-arms during its own RESP cycle
    go(1, 5'h0A, 1, 0);
    step;
    chk("b2b_issue1", {o_phy_request, o_phy_addr, o_grant}, {1'b1, 5'h0A, 2'b10});
    step;
    i_phy_done = 1; i_phy_rd_data = 32'h77;
    step;
    i_phy_done = 0;
    chk("b2b_done1", {o_req1_done, o_req1_rd_data}, {1'b1, 32'h77});
    i_req1_request = 1; i_req1_addr = 5'h0B; i_req1_rdwn = 0; i_req1_wr_data = 32'h0B0B;
    step;
    i_req1_request = 0;
    chk("b2b_idle", {o_phy_request, o_req1_busy}, {1'b0, 1'b1});
    step;
    chk("b2b_issue2", {o_phy_request, o_phy_addr, o_phy_rdwn, o_grant, o_phy_wr_data},
        {1'b1, 5'h0B, 1'b0, 2'b10, 32'h0B0B});
    i_phy_done = 1; i_phy_rd_data = 32'h5;
    step;
    i_phy_done = 0;
    chk("b2b_done2", {o_req1_done, o_req1_err, o_req1_rd_data}, {1'b1, 1'b0, 32'h5});
    step;

    // reset in WAIT: everything clears, stale done ignored, fresh request works
    go(0, 5'h12, 1, 0);
    repeat (3) step;
    chk("rst_pre", {o_grant, o_req0_busy}, {2'b01, 1'b1});
    i_rst_n = 0;
    #1;
    chk("rst_all", |{o_phy_request, o_phy_addr, o_phy_rdwn, o_phy_wr_data, o_grant,
                     o_req0_done, o_req0_rd_data, o_req0_err, o_req0_busy,
                     o_req1_done, o_req1_rd_data, o_req1_err, o_req1_busy}, 0);
    i_rst_n = 1;
    b_d0 = n_d0; b_d1 = n_d1; b_pr = n_pr;
    step;
    i_phy_done = 1; i_phy_rd_data = 32'hDEAD;
    step;
    i_phy_done = 0;
    repeat (2) step;
    chk("rst_stale", n_d0 + n_d1 + n_pr - b_d0 - b_d1 - b_pr, 0);
    go(1, 5'h13, 1, 0);
    step;
    chk("rst_fresh", {o_phy_request, o_phy_addr, o_grant}, {1'b1, 5'h13, 2'b10});
    i_phy_done = 1; i_phy_rd_data = 32'h99;
    step;
    i_phy_done = 0;
    chk("rst_done", {o_req1_done, o_req1_err, o_req1_rd_data}, {1'b1, 1'b0, 32'h99});
    step;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/phy_mgmt_arb.md
Name: phy_mgmt_arb

Overview:
- Shares the single PHY management access engine (addr/rdwn/request/done handshake) between two requesters: port 0 is the link-speed poller, port 1 is the host configuration path.
- Captures single-cycle request pulses and serialises them using round-robin arbitration.
- Supervises each transaction with a timeout, and returns rd_data, a done pulse and an error flag to the requester that owns the transaction.
- Sits between the requesters and the PHY management engine inside the MAC speed-control subsystem.

Parameters:
- TIMEOUT_CYCLES, 4096: maximum number of cycles spent in WAIT before the transaction is aborted with error.
- CNT_W, 13: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_req0_request  in  1  port 0 request pulse (one cycle)
- i_req0_addr  in  5  port 0 PHY register address, sampled with the pulse
- i_req0_rdwn  in  1  port 0 direction, 1=read 0=write, sampled with the pulse
- i_req0_wr_data  in  32  port 0 write data, sampled with the pulse
- o_req0_done  out  1  port 0 completion pulse
- o_req0_rd_data  out  32  port 0 read data, valid while o_req0_done=1
- o_req0_err  out  1  port 0 timeout flag, valid while o_req0_done=1
- o_req0_busy  out  1  port 0 request pending or in flight
- i_req1_request, i_req1_addr, i_req1_rdwn, i_req1_wr_data, o_req1_done, o_req1_rd_data, o_req1_err, o_req1_busy: port 1, identical to port 0
- o_phy_request  out  1  engine request pulse
- o_phy_addr  out  5  engine register address
- o_phy_rdwn  out  1  engine direction
- o_phy_wr_data  out  32  engine write data
- i_phy_done  in  1  engine completion pulse
- i_phy_rd_data  in  32  engine read data, valid while i_phy_done=1
- o_grant  out  2  one-hot owner of the engine; 00 when idle

Behaviour:
- Reset values:
  - All outputs are 0.
  - Both pending flags are cleared and FSM state = IDLE.
  - Round-robin pointer favours port 0.
- Request capture:
  - i_reqX_request=1 while port X is not busy sets pendX and latches addr/rdwn/wr_data into that port's command register.
  - A pulse while o_reqX_busy=1 is dropped; the latched command is unchanged.
  - o_reqX_busy = pendX, registered.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any pend is set, select a winner and go to ISSUE.
  - If both are pending, the port not served last wins. After reset, port 0 wins.
  - On that same edge, register o_phy_request=1, drive o_phy_addr/rdwn/wr_data from the winner's command, set o_grant to the winner, and clear the timeout counter.
  - No-contention latency: request pulse in cycle N -> o_phy_request=1 in cycle N+2.
- ISSUE:
  - o_phy_request is high for exactly this one cycle; it is 0 in every other state.
  - Unconditionally go to WAIT, except that i_phy_done=1 in ISSUE completes the transaction exactly as it would in WAIT.
  - o_phy_addr/rdwn/wr_data hold from ISSUE until return to IDLE.
- WAIT:
  - Counter increments every cycle.
  - i_phy_done=1: latch i_phy_rd_data, err=0, go to RESP.
  - Otherwise, when counter == TIMEOUT_CYCLES: rd_data=32'hFFFF_FFFF, err=1, go to RESP.
  - If done and timeout occur in the same cycle, done wins and err=0.
- RESP:
  - o_reqG_done=1 for one cycle (G = granted port), with rd_data and err valid.
  - For writes, rd_data is the engine value, or all-ones on timeout.
  - Clear pendG, record G as last served, set o_grant=00, go to IDLE.
  - Completion latency: i_phy_done in cycle M -> o_reqG_done in cycle M+1 -> IDLE in M+2.
- A new pulse from port G during its own RESP cycle is accepted: set wins over clear, and the new command is latched.
- i_phy_done in IDLE or RESP, including a late done after a timeout, is ignored and never produces an o_reqX_done.
- o_reqX_done, o_reqX_err and o_reqX_rd_data are 0 outside the done cycle.
- Reset asserted mid-transaction returns everything to reset values immediately. Pending requests are lost and no done is issued.

Test Plan:
- Single read: port 0 pulse, addr 5'h11, rdwn=1 in cycle 0; engine answers done in cycle 6 with 32'h0000_8000 -> o_phy_request=1 only in cycle 2 with addr 5'h11; o_grant=01 during cycles 2-7; o_req0_done=1 and rd_data=32'h0000_8000 in cycle 7; o_req0_busy falls in cycle 8.
- Contention: both ports pulse in the same cycle after reset -> port 0 served first, then port 1. Repeat the simultaneous pulses -> port 1 served first.
- Timeout: port 1 write, engine never responds -> o_req1_done=1, o_req1_err=1, rd_data=32'hFFFF_FFFF exactly TIMEOUT_CYCLES+1 cycles after ISSUE. A late i_phy_done afterwards produces no done on either port.
- Busy drop: a second port 0 pulse with addr 5'h01 while the first (addr 5'h11) is in WAIT -> only one engine request is issued, with addr 5'h11, and only one o_req0_done.
- Back-to-back: port 1 pulses again during its own RESP cycle -> the new command is latched; o_phy_request rises 2 cycles later.
- Reset during WAIT -> all outputs 0 the next cycle; a subsequent i_phy_done is ignored; a fresh request works normally.
